// File: rtl/bus_if_slave.sv
// bus_if_slave: single-beat register-file slave with a configurable number of wait states.
// Every accepted transfer ends in one registered ready pulse; decode misses complete with err.
module bus_if_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        rw,
  input  logic        valid,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          IDXW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       regs [DEPTH];
  logic              hit_q;
  logic              rw_q;
  logic [IDXW-1:0]   idx_q;
  logic [31:0]       data_q;

  logic [31:0]       offset;
  logic              dec_hit;
  logic [IDXW-1:0]   dec_idx;

  // The offset compare is done one bit wider so a bank ending at the top of memory cannot wrap.
  always_comb begin
    offset  = addr - BASE_ADDR;
    dec_hit = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    dec_idx = offset[IDXW+1:2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
      hit_q  <= 1'b0;
      rw_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            hit_q  <= dec_hit;
            rw_q   <= rw;
            idx_q  <= dec_idx;
            data_q <= data;
            if (WAIT_STATES == 0) begin
              state <= ACK;
              ready <= 1'b1;
              err   <= !dec_hit;
              rdata <= (dec_hit && !rw) ? regs[dec_idx] : '0;
            end else begin
              state <= WAIT;
              cnt   <= WS;
            end
          end
        end
        WAIT: begin
          if (!valid) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= ACK;
            cnt   <= '0;
            ready <= 1'b1;
            err   <= !hit_q;
            rdata <= (hit_q && !rw_q) ? regs[idx_q] : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          // A write commits only if the master is still holding the request at the completion edge.
          if (valid && hit_q && rw_q) regs[idx_q] <= data_q;
          state <= IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if_slave.sv
// tb_bus_if_slave: drives a zero-wait and a three-wait instance with directed and random
// transfers and compares every acknowledge against a simple register-bank model.
module tb_bus_if_slave;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       addr;
  logic [31:0]       data;
  logic              rw;
  logic [1:0]        valid;
  logic [1:0]        ready;
  logic [1:0][31:0]  rdata;
  logic [1:0]        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][16];

  always #5 clk = ~clk;

  bus_if_slave #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .rw(rw),
    .valid(valid[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0])
  );

  bus_if_slave #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data(data), .rw(rw),
    .valid(valid[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearModel();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) model[s][i] = '0;
  endtask

  function automatic logic isHit(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h1000) && (a < 32'h1040);
  endfunction

  // One full transfer on instance sel: latency, err, rdata and the single-cycle ready are checked.
  task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] d,
                               input logic w);
    int          lat;
    logic        seen;
    logic        hit;
    logic [31:0] expRdata;
    hit      = isHit(a);
    expRdata = (hit && !w) ? model[sel][(a - 32'h1000) >> 2] : 32'h0;
    @(negedge clk);
    addr = a; data = d; rw = w; valid[sel] = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      if (ready[sel]) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) begin
      checkOutput("ready_timeout", 32'(lat), (sel == 0) ? 32'd0 : 32'd3);
      valid[sel] = 1'b0;
      return;
    end
    checkOutput("latency", 32'(lat), (sel == 0) ? 32'd0 : 32'd3);
    checkOutput("err", {31'b0, err[sel]}, {31'b0, !hit});
    checkOutput("rdata", rdata[sel], expRdata);
    @(posedge clk);
    #1 valid[sel] = 1'b0;
    if (hit && w) model[sel][(a - 32'h1000) >> 2] = d;
    @(negedge clk);
    checkOutput("ready_single", {31'b0, ready[sel]}, 32'd0);
  endtask

  task automatic countReady(input int sel, input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (ready[sel]) n++;
    end
  endtask

  initial begin
    int          n;
    int          r;
    int          sel;
    logic [31:0] a;

    rst_n = 1'b0; valid = '0; addr = '0; data = '0; rw = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_ready", {31'b0, ready[s]}, 32'd0);
      checkOutput("reset_err", {31'b0, err[s]}, 32'd0);
      checkOutput("reset_rdata", rdata[s], 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus(0, 32'h1000 + 32'(4 * i), 32'h0, 1'b0);

    applyStimulus(0, 32'h1000, 32'h0000ABCD, 1'b1);
    applyStimulus(0, 32'h1000, 32'h0, 1'b0);
    applyStimulus(0, 32'h103C, 32'hDEADBEEF, 1'b1);
    applyStimulus(0, 32'h103C, 32'h0, 1'b0);
    applyStimulus(0, 32'h1038, 32'h0, 1'b0);

    applyStimulus(0, 32'h1040, 32'h11111111, 1'b1);
    applyStimulus(0, 32'h0FFC, 32'h22222222, 1'b1);
    applyStimulus(0, 32'h1002, 32'h0, 1'b0);
    applyStimulus(0, 32'h1000, 32'h0, 1'b0);

    applyStimulus(1, 32'h1004, 32'h0, 1'b0);

    // Abort: valid drops while the three-wait instance is still counting.
    @(negedge clk);
    addr = 32'h1004; rw = 1'b0; valid[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 valid[1] = 1'b0;
    countReady(1, 8, n);
    checkOutput("abort_no_ready", 32'(n), 32'd0);
    applyStimulus(1, 32'h1004, 32'h0, 1'b0);

    // Reset pulse in the middle of a waited write.
    @(negedge clk);
    addr = 32'h1008; data = 32'h12345678; rw = 1'b1; valid[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    countReady(1, 8, n);
    checkOutput("reset_abort_no_ready", 32'(n), 32'd0);
    applyStimulus(1, 32'h1008, 32'h0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      sel = k % 2;
      r   = $urandom_range(0, 9);
      if (r < 7)      a = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      else if (r == 7) a = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h1040 + 32'(4 * $urandom_range(0, 8));
      else             a = 32'h0FC0 + 32'(4 * $urandom_range(0, 15));
      applyStimulus(sel, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
